// File: rtl/blink_pkg.sv
// Shared types and default constants for the blink monitor slice.
package blink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_LOCKED,
    ST_LOST
  } state_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TOL         = 1;
  localparam int DEF_LOCK_COUNT  = 4;
  localparam int DEF_TIMEOUT     = 1000;
  localparam int DEF_FILTER_LEN  = 3;

endpackage

// File: rtl/blink_monitor_if.sv
// Blink input and status bundle; master is the monitor, slave the source/consumer side.
interface blink_monitor_if
  import blink_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             blink_in;
  logic             level;
  logic [CNT_W-1:0] half_period;
  logic             period_valid;
  logic             locked;
  logic             timeout;
  logic [15:0]      edge_count;

  modport master (
    input  blink_in,
    output level, half_period, period_valid, locked, timeout, edge_count
  );

  modport slave (
    output blink_in,
    input  level, half_period, period_valid, locked, timeout, edge_count
  );

endinterface

// File: rtl/blink_sync.sv
// Synchronizer chain for the asynchronous blink input, with an optional glitch
// filter selected by BLINK_MONITOR_GLITCH_FILTER_EN.
module blink_sync
  import blink_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILTER_LEN  = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic blink_in,
  output logic level
);

  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_err
    $error("blink_sync: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_p0;

  always_ff @(posedge clk) begin
    if (rst) sync_p0 <= '0;
    else     sync_p0 <= {sync_p0[SYNC_STAGES-2:0], blink_in};
  end

`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
  localparam int HOLD_W = $clog2(FILTER_LEN + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              level_p1;

  // filter stage: follow the synchronized input only after it differs for FILTER_LEN cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      level_p1 <= 1'b0;
    end else if (sync_p0[SYNC_STAGES-1] == level_p1) begin
      hold_cnt <= '0;
    end else if (hold_cnt == HOLD_W'(FILTER_LEN - 1)) begin
      hold_cnt <= '0;
      level_p1 <= sync_p0[SYNC_STAGES-1];
    end else begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  assign level = level_p1;
`else
  assign level = sync_p0[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/blink_monitor.sv
// Measures half-periods of a synchronized blink signal, reports lock and loss.
// Optional glitch filter: define BLINK_MONITOR_GLITCH_FILTER_EN.
module blink_monitor
  import blink_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TOL         = DEF_TOL,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int FILTER_LEN  = DEF_FILTER_LEN
) (
  input  logic            clk,
  input  logic            rst,
  blink_monitor_if.master bus
);

  if (LOCK_COUNT < 2 || TIMEOUT < 1 ||
      longint'(TIMEOUT) > (longint'(1) << CNT_W) - 1) begin : g_param_err
    $error("blink_monitor: LOCK_COUNT must be >= 2 and TIMEOUT in 1..2^CNT_W-1");
  end

  localparam int               RUN_W       = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [RUN_W-1:0] LOCK_RUN    = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] LOCK_PRE    = RUN_W'(LOCK_COUNT - 1);

  function automatic logic is_match(input logic [CNT_W-1:0] a,
                                    input logic [CNT_W-1:0] b);
    logic signed [CNT_W:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    if (diff < 0) diff = -diff;
    return diff <= $signed((CNT_W + 1)'(TOL));
  endfunction

  logic level_p0, level_p1, edge_p0;

  blink_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .blink_in (bus.blink_in),
    .level    (level_p0)
  );

  // edge stage: compare the level with its registered copy
  always_ff @(posedge clk) begin
    if (rst) level_p1 <= 1'b0;
    else     level_p1 <= level_p0;
  end

  assign edge_p0 = level_p0 ^ level_p1;

  state_t           state;
  logic [CNT_W-1:0] cnt, half_period;
  logic [RUN_W-1:0] run;
  logic             prev_valid, period_valid, locked, timeout, match;
  logic [15:0]      edge_count;

  // half_period doubles as the previous measurement
  assign match = prev_valid && is_match(cnt, half_period);

  // measurement stage: FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      run          <= '0;
      prev_valid   <= 1'b0;
      half_period  <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      edge_count   <= '0;
    end else begin
      period_valid <= 1'b0;
      if (edge_p0) begin
        edge_count <= edge_count + 16'd1;
        cnt        <= CNT_W'(1);
        unique case (state)
          ST_IDLE, ST_LOST: begin
            state      <= ST_MEASURE;
            prev_valid <= 1'b0;
            run        <= '0;
            timeout    <= 1'b0;
          end
          default: begin
            period_valid <= 1'b1;
            half_period  <= cnt;
            prev_valid   <= 1'b1;
            if (match && run >= LOCK_PRE) begin
              run    <= LOCK_RUN;
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end else if (match) begin
              run <= run + RUN_W'(1);
            end else begin
              run    <= RUN_W'(1);
              state  <= ST_MEASURE;
              locked <= 1'b0;
            end
          end
        endcase
      end else if (state != ST_LOST) begin
        if (cnt == TIMEOUT_CNT) begin
          state      <= ST_LOST;
          timeout    <= 1'b1;
          locked     <= 1'b0;
          prev_valid <= 1'b0;
          run        <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.level        = level_p0;
  assign bus.half_period  = half_period;
  assign bus.period_valid = period_valid;
  assign bus.locked       = locked;
  assign bus.timeout      = timeout;
  assign bus.edge_count   = edge_count;

endmodule

// File: tb/tb_blink_monitor.sv
// Bench for blink_monitor: edge-time model of the measurement rules plus directed scenarios.
module tb_blink_monitor;
  import blink_pkg::*;

  localparam int CNT_W      = 16;
  localparam int S          = 2;
  localparam int TOL        = 1;
  localparam int LOCK_COUNT = 4;
  localparam int TIMEOUT    = 1000;
  localparam int F          = 3;
  localparam int MAXC       = 8192;

  logic clk, rst;
  blink_monitor_if #(.CNT_W(CNT_W)) bus();

  blink_monitor #(
    .CNT_W(CNT_W), .SYNC_STAGES(S), .TOL(TOL),
    .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT), .FILTER_LEN(F)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: level per cycle from input samples, edge times, and the list of
  // half-periods in the current measuring segment.
  int  cyc = 0;
  int  last_rst = 0;
  int  last_ref = 0;
  bit  started = 0;
  bit  samp_a [MAXC];
  bit  u_a    [MAXC];
  bit  l_a    [MAXC];
  bit  seg_open, lost, m_pv, m_locked;
  int  m_hp, m_ec;
  int  meas[$];

  always @(posedge clk) begin
    bit edge_now;
    int run, d;
`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
    bit chg;
`endif
    cyc = cyc + 1;
    if (cyc < MAXC) begin
      if (rst) begin
        last_rst = cyc; u_a[cyc] = 0; l_a[cyc] = 0;
        seg_open = 0; lost = 0; meas.delete();
        m_hp = 0; m_pv = 0; m_ec = 0; last_ref = cyc + 1; started = 1;
      end else begin
        samp_a[cyc] = bus.blink_in;
        u_a[cyc] = (cyc - S + 1 > last_rst) ? samp_a[cyc - S + 1] : 1'b0;
`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
        chg = (cyc - F > last_rst);
        if (chg) for (int k = 1; k <= F; k++) if (u_a[cyc - k] == l_a[cyc - 1]) chg = 0;
        l_a[cyc] = chg ? ~l_a[cyc - 1] : l_a[cyc - 1];
`else
        l_a[cyc] = u_a[cyc];
`endif
        m_pv = 0;
        edge_now = (cyc - 1 > last_rst) && (l_a[cyc - 1] != l_a[cyc - 2]);
        if (edge_now) begin
          m_ec = (m_ec + 1) % 65536;
          if (!seg_open) begin
            seg_open = 1; lost = 0; meas.delete();
          end else begin
            m_pv = 1; m_hp = cyc - last_ref; meas.push_back(m_hp);
          end
          last_ref = cyc;
        end else if (!lost && cyc == last_ref + TIMEOUT) begin
          lost = 1; seg_open = 0; meas.delete();
        end
      end
      run = 0;
      if (meas.size() > 0) begin
        run = 1;
        for (int i = meas.size() - 1; i > 0; i--) begin
          d = meas[i] - meas[i - 1];
          if (d < 0) d = -d;
          if (d <= TOL) run++;
          else break;
        end
      end
      m_locked = (run >= LOCK_COUNT);
    end
  end

  always @(negedge clk) begin
    if (started && cyc < MAXC) begin
      chk("level",        32'(bus.level),        32'(l_a[cyc]));
      chk("half_period",  32'(bus.half_period),  32'(m_hp));
      chk("period_valid", 32'(bus.period_valid), 32'(m_pv));
      chk("locked",       32'(bus.locked),       32'(m_locked));
      chk("timeout",      32'(bus.timeout),      32'(lost));
      chk("edge_count",   32'(bus.edge_count),   32'(m_ec));
    end
  end

  // toggle the input, then hold it for n cycles counting period_valid pulses
  task automatic half(input int n, output int pulses);
    pulses = 0;
    bus.blink_in = ~bus.blink_in;
    repeat (n) begin
      @(negedge clk);
      if (bus.period_valid) pulses++;
    end
  endtask

  initial begin
    int pc, sum, t0, t1, ec0;
    bit got;
    rst = 1'b1;
    bus.blink_in = 1'b0;

    // 1: reset, toggling during reset is ignored
    repeat (2) @(negedge clk);
    bus.blink_in = 1'b1;
    repeat (2) @(negedge clk);
    bus.blink_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_level",    32'(bus.level), 0);
    chk("rst_hp",       32'(bus.half_period), 0);
    chk("rst_pv",       32'(bus.period_valid), 0);
    chk("rst_locked",   32'(bus.locked), 0);
    chk("rst_timeout",  32'(bus.timeout), 0);
    chk("rst_ec",       32'(bus.edge_count), 0);
    chk("rst_state",    32'(u_dut.state), 32'(ST_IDLE));

    // 2: square wave, half-period 7
    sum = 0;
    half(7, pc);
    chk("first_edge_pulses", 32'(pc), 0);
    repeat (4) begin half(7, pc); sum += pc; end
    chk("sq7_pulses", 32'(sum), 4);
    chk("sq7_hp",     32'(bus.half_period), 7);
    chk("sq7_locked", 32'(bus.locked), 1);
    chk("sq7_ec",     32'(bus.edge_count), 5);

    // 3: tolerated jitter, then a jump to 12 and relock
    half(8, pc); half(7, pc); half(12, pc);
    chk("jitter_locked", 32'(bus.locked), 1);
    half(12, pc);
    chk("jump_hp",     32'(bus.half_period), 12);
    chk("jump_locked", 32'(bus.locked), 0);
    repeat (3) half(12, pc);
    chk("relock",      32'(bus.locked), 1);

    // 4: input stops; timeout exactly TIMEOUT cycles after the last pulse
    bus.blink_in = ~bus.blink_in;
    got = 0; t0 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.period_valid) begin got = 1; t0 = cyc; break; end
    end
    chk("last_pulse_seen", 32'(got), 1);
    got = 0; t1 = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (bus.timeout) begin got = 1; t1 = cyc; break; end
    end
    chk("timeout_seen",   32'(got), 1);
    chk("timeout_delay",  32'(t1 - t0), 1000);
    chk("timeout_locked", 32'(bus.locked), 0);
    half(8, pc);
    chk("lost_edge_pulses",  32'(pc), 0);
    chk("lost_edge_timeout", 32'(bus.timeout), 0);
    half(8, pc);
    chk("after_lost_pulses", 32'(pc), 1);
    chk("after_lost_hp",     32'(bus.half_period), 8);

    // 5: one-cycle reset mid-lock, then relock within five edges
    repeat (5) half(7, pc);
    chk("pre_rst_locked", 32'(bus.locked), 1);
    rst = 1'b1;
    bus.blink_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_hp",     32'(bus.half_period), 0);
    chk("mid_rst_locked", 32'(bus.locked), 0);
    chk("mid_rst_ec",     32'(bus.edge_count), 0);
    chk("mid_rst_level",  32'(bus.level), 0);
    repeat (5) half(7, pc);
    chk("relock_after_rst", 32'(bus.locked), 1);
    chk("relock_ec",        32'(bus.edge_count), 5);

    // 6: single-cycle low glitch on a steady high input
    bus.blink_in = 1'b1;
    repeat (20) @(negedge clk);
    ec0 = 32'(bus.edge_count);
    bus.blink_in = 1'b0;
    @(negedge clk);
    bus.blink_in = 1'b1;
    repeat (20) @(negedge clk);
`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
    chk("glitch_ec", 32'(bus.edge_count), 32'(ec0));
`else
    chk("glitch_ec", 32'(bus.edge_count), 32'(ec0 + 2));
    chk("glitch_hp", 32'(bus.half_period), 1);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
